// File: rtl/motor_ctrl_pkg.sv
// Shared widths, FSM state type and arithmetic types for the motor PI speed controller.
package motor_ctrl_pkg;

  localparam int RPM_W     = 21;
  localparam int GAIN_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int DUTY_W    = 10;
  localparam int PROD_W    = RPM_W + GAIN_W + 2;
  localparam int SUM_W     = PROD_W + 1;
  localparam int DUTY_MAX  = (2 ** DUTY_W) - 1;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MUL,
    INTEG,
    SUM
  } pi_state_t;

  typedef logic signed [RPM_W:0]    rpm_err_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running period counter; tick_out is high for the single cycle the count wraps.
module sample_tick_gen #(
  parameter int SAMPLE_CYCLES = 1_250_000
) (
  input  logic clk_in,
  input  logic reset_n_in,
  output logic tick_out
);

  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_W'(SAMPLE_CYCLES - 1));
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  assign tick_out = wrap;

endmodule

// File: rtl/motor_speed_pi_controller.sv
// PI speed regulator: one saturated, anti-windup duty update per control period.
//   state | meaning
//   IDLE  | waiting for the period tick while enabled
//   ERR   | inputs latched, speed error formed
//   MUL   | proportional and integral products formed
//   INTEG | integrator advanced or held, clamped
//   SUM   | P+I scaled, clamped to duty range, published
module motor_speed_pi_controller
  import motor_ctrl_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 1_250_000,
  parameter int INT_LIMIT     = 1 << 30
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              enable_in,
  input  logic [RPM_W-1:0]  target_rpm_in,
  input  logic [RPM_W-1:0]  actual_rpm_in,
  input  logic [GAIN_W-1:0] kp_in,
  input  logic [GAIN_W-1:0] ki_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid_out,
  output logic              saturated_out
);

  logic tick;

  sample_tick_gen #(.SAMPLE_CYCLES(SAMPLE_CYCLES)) u_tick (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .tick_out   (tick)
  );

  pi_state_t          state_q, state_d;
  logic [RPM_W-1:0]   tgt_q, tgt_d, act_q, act_d;
  logic [GAIN_W-1:0]  kp_q, kp_d, ki_q, ki_d;
  rpm_err_t           err_q, err_d;
  prod_t              p_q, p_d, i_inc_q, i_inc_d, integ_q, integ_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic               valid_q, valid_d;
  logic               sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
  logic               en_q, en_d;
  sum_t               integ_sum, s_full;
  logic               hold;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    act_d     = act_q;
    kp_d      = kp_q;
    ki_d      = ki_q;
    err_d     = err_q;
    p_d       = p_q;
    i_inc_d   = i_inc_q;
    integ_d   = integ_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    sat_hi_d  = sat_hi_q;
    sat_lo_d  = sat_lo_q;
    en_d      = enable_in;
    integ_sum = sum_t'(integ_q) + sum_t'(i_inc_q);
    s_full    = (sum_t'(p_q) + sum_t'(integ_q)) >>> FRAC_BITS;
    // Freeze the integrator while the error would push further into the active clamp.
    hold      = (sat_hi_q && !err_q[RPM_W] && (err_q != '0)) || (sat_lo_q && err_q[RPM_W]);

    if (integ_sum > sum_t'(INT_LIMIT))       integ_sum = sum_t'(INT_LIMIT);
    else if (integ_sum < sum_t'(-INT_LIMIT)) integ_sum = sum_t'(-INT_LIMIT);

    case (state_q)
      IDLE: begin
        if (tick && enable_in) begin
          state_d = ERR;
          tgt_d   = target_rpm_in;
          act_d   = actual_rpm_in;
          kp_d    = kp_in;
          ki_d    = ki_in;
        end
      end
      ERR: begin
        err_d   = $signed({1'b0, tgt_q}) - $signed({1'b0, act_q});
        state_d = MUL;
      end
      MUL: begin
        p_d     = prod_t'(err_q) * prod_t'($signed({1'b0, kp_q}));
        i_inc_d = prod_t'(err_q) * prod_t'($signed({1'b0, ki_q}));
        state_d = INTEG;
      end
      INTEG: begin
        if (!hold) integ_d = prod_t'(integ_sum);
        state_d = SUM;
      end
      SUM: begin
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
        if (s_full[SUM_W-1]) begin
          duty_d   = '0;
          sat_lo_d = 1'b1;
        end else if (s_full > sum_t'(DUTY_MAX)) begin
          duty_d   = '1;
          sat_hi_d = 1'b1;
        end else begin
          duty_d   = s_full[DUTY_W-1:0];
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything; the enable falling edge publishes the forced zero once.
    if (!enable_in) begin
      state_d  = IDLE;
      integ_d  = '0;
      duty_d   = '0;
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
      valid_d  = en_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      act_q    <= '0;
      kp_q     <= '0;
      ki_q     <= '0;
      err_q    <= '0;
      p_q      <= '0;
      i_inc_q  <= '0;
      integ_q  <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      act_q    <= act_d;
      kp_q     <= kp_d;
      ki_q     <= ki_d;
      err_q    <= err_d;
      p_q      <= p_d;
      i_inc_q  <= i_inc_d;
      integ_q  <= integ_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
      en_q     <= en_d;
    end
  end

  assign duty_out       = duty_q;
  assign duty_valid_out = valid_q;
  assign saturated_out  = sat_hi_q | sat_lo_q;

  a_tick_only_in_idle : assert property (
    @(posedge clk_in) disable iff (!reset_n_in) tick |-> (state_q == IDLE)
  );

endmodule

// File: tb/tb_motor_speed_pi_controller.sv
// Directed bench for motor_speed_pi_controller with a 100-cycle control period.
module tb_motor_speed_pi_controller;
  import motor_ctrl_pkg::*;

  logic              clk_in;
  logic              reset_n_in;
  logic              enable_in;
  logic [RPM_W-1:0]  target_rpm_in;
  logic [RPM_W-1:0]  actual_rpm_in;
  logic [GAIN_W-1:0] kp_in;
  logic [GAIN_W-1:0] ki_in;
  logic [DUTY_W-1:0] duty_out;
  logic              duty_valid_out;
  logic              saturated_out;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  motor_speed_pi_controller #(.SAMPLE_CYCLES(100)) dut (
    .clk_in         (clk_in),
    .reset_n_in     (reset_n_in),
    .enable_in      (enable_in),
    .target_rpm_in  (target_rpm_in),
    .actual_rpm_in  (actual_rpm_in),
    .kp_in          (kp_in),
    .ki_in          (ki_in),
    .duty_out       (duty_out),
    .duty_valid_out (duty_valid_out),
    .saturated_out  (saturated_out)
  );

  // cyc counts edges since reset release: tick is visible at cyc%100==99, valid at cyc%100==4.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic wait_update(output int found);
    found = 0;
    for (int i = 0; i < 150 && found == 0; i++) begin
      step();
      if (duty_valid_out === 1'b1) found = 1;
    end
  endtask

  task automatic test_reset();
    int bad;
    reset_n_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      enable_in     = 1'($urandom_range(0, 1));
      target_rpm_in = RPM_W'($urandom);
      actual_rpm_in = RPM_W'($urandom);
      kp_in         = GAIN_W'($urandom);
      ki_in         = GAIN_W'($urandom);
      step();
      n_total++;
      if ({duty_out, duty_valid_out, saturated_out} !== '0)
        $display("FAIL reset_hold[%0d]: duty=%0d valid=%b sat=%b, need all 0", i, duty_out, duty_valid_out, saturated_out);
      else n_pass++;
    end
    enable_in = 1'b1; kp_in = 16'd256; ki_in = 16'd0;
    target_rpm_in = 21'd300; actual_rpm_in = 21'd0;
    reset_n_in = 1'b1;
    cyc = 0;
    bad = 0;
    for (int i = 0; i < 103; i++) begin
      step();
      if ({duty_out, duty_valid_out, saturated_out} !== '0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL reset_release: %0d nonzero-output cycles before first update, need 0", bad);
    else n_pass++;
  endtask

  task automatic test_p_only();
    int f;
    wait_update(f);
    n_total++;
    if (f == 0 || cyc != 104) $display("FAIL p_latency: valid at cyc=%0d found=%0d, need cyc=104", cyc, f);
    else n_pass++;
    n_total++;
    if (duty_out !== 10'd300) $display("FAIL p_duty: got %0d, need 300", duty_out);
    else n_pass++;
    n_total++;
    if (saturated_out !== 1'b0) $display("FAIL p_sat: got %b, need 0", saturated_out);
    else n_pass++;
    step();
    n_total++;
    if (duty_valid_out !== 1'b0) $display("FAIL p_pulse_width: valid=%b one cycle later, need 0", duty_valid_out);
    else n_pass++;
    wait_update(f);
    n_total++;
    if (f == 0 || cyc != 204 || duty_out !== 10'd300)
      $display("FAIL p_repeat: cyc=%0d duty=%0d, need cyc=204 duty=300", cyc, duty_out);
    else n_pass++;
  endtask

  task automatic test_neg_clamp();
    int f;
    actual_rpm_in = 21'd450;
    wait_update(f);
    n_total++;
    if (f == 0 || (cyc % 100) != 4 || duty_out !== 10'd0 || saturated_out !== 1'b1)
      $display("FAIL neg_clamp: cyc=%0d duty=%0d sat=%b, need cyc%%100=4 duty=0 sat=1", cyc, duty_out, saturated_out);
    else n_pass++;
  endtask

  task automatic test_integral();
    int f;
    int exp_duty;
    logic exp_sat;
    kp_in = 16'd0; ki_in = 16'd256;
    target_rpm_in = 21'd400; actual_rpm_in = 21'd300;
    for (int k = 1; k <= 12; k++) begin
      exp_duty = (k <= 10) ? 100 * k : 1023;
      exp_sat  = (k > 10);
      wait_update(f);
      n_total++;
      if (f == 0 || duty_out !== DUTY_W'(exp_duty) || saturated_out !== exp_sat)
        $display("FAIL integ_step[%0d]: duty=%0d sat=%b, need duty=%0d sat=%b", k, duty_out, saturated_out, exp_duty, exp_sat);
      else n_pass++;
    end
    actual_rpm_in = 21'd500;
    wait_update(f);
    n_total++;
    if (f == 0 || duty_out !== 10'd1000 || saturated_out !== 1'b0)
      $display("FAIL anti_windup: duty=%0d sat=%b, need duty=1000 sat=0", duty_out, saturated_out);
    else n_pass++;
  endtask

  task automatic test_pos_clamp();
    int f;
    enable_in = 1'b0;
    step();
    n_total++;
    if (duty_out !== 10'd0 || duty_valid_out !== 1'b1 || saturated_out !== 1'b0)
      $display("FAIL disable_idle: duty=%0d valid=%b sat=%b, need 0/1/0", duty_out, duty_valid_out, saturated_out);
    else n_pass++;
    step();
    kp_in = 16'd1024; ki_in = 16'd0;
    target_rpm_in = 21'd1000; actual_rpm_in = 21'd0;
    enable_in = 1'b1;
    wait_update(f);
    n_total++;
    if (f == 0 || (cyc % 100) != 4 || duty_out !== 10'd1023 || saturated_out !== 1'b1)
      $display("FAIL pos_clamp: cyc=%0d duty=%0d sat=%b, need cyc%%100=4 duty=1023 sat=1", cyc, duty_out, saturated_out);
    else n_pass++;
  endtask

  task automatic test_disable_mid();
    int f;
    int bad;
    enable_in = 1'b0;
    step();
    step();
    kp_in = 16'd0; ki_in = 16'd256;
    target_rpm_in = 21'd400; actual_rpm_in = 21'd300;
    enable_in = 1'b1;
    wait_update(f);
    n_total++;
    if (f == 0 || duty_out !== 10'd100) $display("FAIL dis_pre: duty=%0d, need 100", duty_out);
    else n_pass++;
    for (int i = 0; i < 200 && (cyc % 100) != 1; i++) step();
    enable_in = 1'b0;
    step();
    n_total++;
    if (duty_out !== 10'd0 || duty_valid_out !== 1'b1 || saturated_out !== 1'b0)
      $display("FAIL dis_mul: duty=%0d valid=%b sat=%b, need 0/1/0", duty_out, duty_valid_out, saturated_out);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 200 && (cyc % 100) != 10; i++) begin
      step();
      if (duty_valid_out !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL dis_no_late_valid: %0d stray valid cycles, need 0", bad);
    else n_pass++;
    enable_in = 1'b1;
    wait_update(f);
    n_total++;
    if (f == 0 || (cyc % 100) != 4 || duty_out !== 10'd100)
      $display("FAIL dis_reenable: cyc=%0d duty=%0d, need cyc%%100=4 duty=100", cyc, duty_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int f;
    for (int i = 0; i < 200 && (cyc % 100) != 2; i++) step();
    reset_n_in = 1'b0;
    step();
    n_total++;
    if (duty_out !== 10'd0 || duty_valid_out !== 1'b0 || saturated_out !== 1'b0)
      $display("FAIL rst_integ: duty=%0d valid=%b sat=%b, need 0/0/0", duty_out, duty_valid_out, saturated_out);
    else n_pass++;
    reset_n_in = 1'b1;
    cyc = 0;
    wait_update(f);
    n_total++;
    if (f == 0 || cyc != 104 || duty_out !== 10'd100 || saturated_out !== 1'b0)
      $display("FAIL rst_recover: cyc=%0d duty=%0d sat=%b, need cyc=104 duty=100 sat=0", cyc, duty_out, saturated_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_neg_clamp();
    test_integral();
    test_pos_clamp();
    test_disable_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
